// File: rtl/fu_pkg.sv
// Shared constants and instruction layout for the tp_fu overlay sequencer.
package fu_pkg;

  localparam int unsigned INST_W  = 24;
  localparam int unsigned RADDR_W = 6;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_NOP  = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADD  = 6'b000001;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000010;
  localparam logic [OP_W-1:0] OP_MUL  = 6'b000011;
  localparam logic [OP_W-1:0] OP_MULI = 6'b000111;

  // Opcode bit that marks the src2 field as an immediate.
  localparam int unsigned OP_IMM_BIT = 2;

  localparam int unsigned OP_LSB   = 18;
  localparam int unsigned DST_LSB  = 12;
  localparam int unsigned SRC1_LSB = 6;
  localparam int unsigned SRC2_LSB = 0;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [RADDR_W-1:0] dst;
    logic [RADDR_W-1:0] src1;
    logic [RADDR_W-1:0] src2;
  } inst_t;

endpackage

// File: rtl/fu_scoreboard.sv
// In-flight destination tracker for the fixed-latency FU: hazard detect and writeback strobe.
module fu_scoreboard
  import fu_pkg::*;
#(
  parameter int unsigned FU_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [RADDR_W-1:0] push_dst,
  input  logic [RADDR_W-1:0] q_src1,
  input  logic [RADDR_W-1:0] q_src2,
  input  logic [RADDR_W-1:0] q_dst,
  input  logic               q_src2_is_imm,
  output logic               hazard,
  output logic               pipe_empty,
  output logic               wb_valid,
  output logic [RADDR_W-1:0] wb_addr
);

  logic [FU_LAT-1:0]              pipe_v_q, pipe_v_d;
  logic [FU_LAT-1:0][RADDR_W-1:0] pipe_dst_q, pipe_dst_d;
  logic                           wb_valid_q, wb_valid_d;
  logic [RADDR_W-1:0]             wb_addr_q, wb_addr_d;

  // Shift every cycle; the last stage feeds the registered writeback strobe.
  always_comb begin
    pipe_v_d      = pipe_v_q;
    pipe_dst_d    = pipe_dst_q;
    pipe_v_d[0]   = push;
    pipe_dst_d[0] = push_dst;
    for (int unsigned i = 1; i < FU_LAT; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_dst_d[i] = pipe_dst_q[i-1];
    end
    wb_valid_d = pipe_v_q[FU_LAT-1];
    wb_addr_d  = pipe_v_q[FU_LAT-1] ? pipe_dst_q[FU_LAT-1] : '0;
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < FU_LAT; i++) begin
      if (pipe_v_q[i] && ((pipe_dst_q[i] == q_src1) ||
                          (!q_src2_is_imm && (pipe_dst_q[i] == q_src2)) ||
                          (pipe_dst_q[i] == q_dst))) begin
        hazard = 1'b1;
      end
    end
  end

  assign pipe_empty = ~|pipe_v_q;
  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q   <= '0;
      pipe_dst_q <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
    end else begin
      pipe_v_q   <= pipe_v_d;
      pipe_dst_q <= pipe_dst_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
    end
  end

endmodule

// File: rtl/fu_inst_sequencer.sv
// Host-loaded instruction memory plus IDLE/RUN/DRAIN sequencer issuing one instruction per cycle,
// stalling on scoreboard hazards.
module fu_inst_sequencer
  import fu_pkg::*;
#(
  parameter int unsigned IMEM_AW = 6,
  parameter int unsigned FU_LAT  = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               bus_clk,
  input  logic               rst_n,
  input  logic               ld_wren,
  input  logic [IMEM_AW-1:0] ld_addr,
  input  logic [INST_W-1:0]  ld_data,
  input  logic [IMEM_AW:0]   prog_len,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               issue_valid,
  output logic [INST_W-1:0]  issue_inst,
  output logic               wb_valid,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned DEPTH = 1 << IMEM_AW;
  localparam int unsigned LEN_W = IMEM_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               issue_valid_q, issue_valid_d;
  logic [INST_W-1:0]  issue_inst_q, issue_inst_d;

  logic [INST_W-1:0]  imem_q [DEPTH];
  inst_t              cur_inst;
  logic [LEN_W-1:0]   len_clamped;
  logic               last_pc;
  logic               push;
  logic               hazard;
  logic               pipe_empty;

  assign cur_inst    = inst_t'(imem_q[pc_q]);
  assign len_clamped = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
  assign last_pc     = ({1'b0, pc_q} == (len_q - LEN_W'(1)));

  // Host writes land only while idle so a running program cannot be corrupted.
  always_ff @(posedge bus_clk) begin
    if (ld_wren && (state_q == S_IDLE)) begin
      imem_q[ld_addr] <= ld_data;
    end
  end

  fu_scoreboard #(
    .FU_LAT (FU_LAT)
  ) u_scoreboard (
    .clk           (bus_clk),
    .rst_n         (rst_n),
    .push          (push),
    .push_dst      (cur_inst.dst),
    .q_src1        (cur_inst.src1),
    .q_src2        (cur_inst.src2),
    .q_dst         (cur_inst.dst),
    .q_src2_is_imm (cur_inst.op[OP_IMM_BIT]),
    .hazard        (hazard),
    .pipe_empty    (pipe_empty),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    len_d         = len_q;
    stall_d       = stall_q;
    done_d        = 1'b0;
    issue_valid_d = 1'b0;
    issue_inst_d  = '0;
    push          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            pc_d    = '0;
            stall_d = '0;
            len_d   = len_clamped;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (hazard) begin
          if (stall_q != {CNT_W{1'b1}}) stall_d = stall_q + CNT_W'(1);
        end else begin
          if (cur_inst.op != OP_NOP) begin
            issue_valid_d = 1'b1;
            issue_inst_d  = cur_inst;
            push          = 1'b1;
          end
          // pc parks on the last instruction rather than wrapping.
          if (last_pc) state_d = S_DRAIN;
          else         pc_d    = pc_q + IMEM_AW'(1);
        end
      end
      S_DRAIN: begin
        if (pipe_empty) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      len_q         <= '0;
      stall_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_inst_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      len_q         <= len_d;
      stall_q       <= stall_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      issue_valid_q <= issue_valid_d;
      issue_inst_q  <= issue_inst_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign issue_valid = issue_valid_q;
  assign issue_inst  = issue_inst_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_fu_inst_sequencer.sv
// Directed bench for fu_inst_sequencer; cycle 0 of a run is two cycles after start is sampled.
module tb_fu_inst_sequencer;

  localparam int unsigned IMEM_AW = 6;
  localparam int unsigned FU_LAT  = 4;
  localparam int unsigned CNT_W   = 16;

  localparam logic [5:0] T_NOP  = 6'd0;
  localparam logic [5:0] T_ADD  = 6'd1;
  localparam logic [5:0] T_MUL  = 6'd3;
  localparam logic [5:0] T_MULI = 6'd7;

  logic               bus_clk = 1'b0;
  logic               rst_n;
  logic               ld_wren;
  logic [IMEM_AW-1:0] ld_addr;
  logic [23:0]        ld_data;
  logic [IMEM_AW:0]   prog_len;
  logic               start;
  logic               busy;
  logic               done;
  logic               issue_valid;
  logic [23:0]        issue_inst;
  logic               wb_valid;
  logic [5:0]         wb_addr;
  logic [CNT_W-1:0]   stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  int s_cyc    = 0;
  bit clr_req  = 1'b0;
  bit to;

  int          iss_cyc[$];
  logic [23:0] iss_inst[$];
  int          wb_cyc[$];
  logic [5:0]  wb_adr[$];
  int          done_cyc[$];
  logic        done_busy[$];

  fu_inst_sequencer #(
    .IMEM_AW (IMEM_AW),
    .FU_LAT  (FU_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .bus_clk     (bus_clk),
    .rst_n       (rst_n),
    .ld_wren     (ld_wren),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .prog_len    (prog_len),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .issue_valid (issue_valid),
    .issue_inst  (issue_inst),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .stall_cnt   (stall_cnt)
  );

  always #5 bus_clk = ~bus_clk;
  always @(posedge bus_clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle.
  always @(negedge bus_clk) begin
    if (clr_req) begin
      iss_cyc.delete(); iss_inst.delete(); wb_cyc.delete();
      wb_adr.delete(); done_cyc.delete(); done_busy.delete();
    end
    if (issue_valid) begin iss_cyc.push_back(cyc); iss_inst.push_back(issue_inst); end
    if (wb_valid) begin wb_cyc.push_back(cyc); wb_adr.push_back(wb_addr); end
    if (done) begin done_cyc.push_back(cyc); done_busy.push_back(busy); end
  end

  function automatic logic [23:0] mk(input logic [5:0] op, input logic [5:0] d,
                                     input logic [5:0] a, input logic [5:0] b);
    return {op, d, a, b};
  endfunction

  task automatic load_inst(input logic [IMEM_AW-1:0] a, input logic [23:0] d);
    @(posedge bus_clk); #1;
    ld_wren = 1'b1; ld_addr = a; ld_data = d;
    @(posedge bus_clk); #1;
    ld_wren = 1'b0;
  endtask

  task automatic kick(input logic [IMEM_AW:0] len);
    @(posedge bus_clk); #1;
    prog_len = len; start = 1'b1; clr_req = 1'b1; s_cyc = cyc; base = cyc + 2;
    @(posedge bus_clk); #1;
    start = 1'b0; clr_req = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge bus_clk); #1;
      if (done_cyc.size() != 0) begin timed_out = 1'b0; break; end
    end
    repeat (3) begin @(posedge bus_clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; #2 rst_n = 1'b0;
    repeat (2) @(posedge bus_clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %0b expected 0", issue_valid); end
    n_checks++; if (issue_inst !== 24'h0) begin n_fail++; $display("FAIL reset_issue_inst: got %h expected 0", issue_inst); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0b expected 0", wb_valid); end
    n_checks++; if (wb_addr !== 6'd0) begin n_fail++; $display("FAIL reset_wb_addr: got %0d expected 0", wb_addr); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    rst_n = 1'b1;
    repeat (2) @(posedge bus_clk);
    #1;
  endtask

  task automatic test_independent;
    for (int k = 0; k < 4; k++) load_inst(6'(k), mk(T_MULI, 6'(k), 6'd20, 6'd3));
    kick(7'd4);
    wait_done(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL indep_timeout: done not seen within 100 cycles"); end
    n_checks++; if (iss_cyc.size() != 4) begin n_fail++; $display("FAIL indep_issue_count: got %0d expected 4", iss_cyc.size()); end
    for (int i = 0; i < 4 && i < iss_cyc.size(); i++) begin
      n_checks++; if (iss_cyc[i] !== base + i) begin n_fail++; $display("FAIL indep_issue_cyc[%0d]: got %0d expected %0d", i, iss_cyc[i] - base, i); end
      n_checks++; if (iss_inst[i] !== mk(T_MULI, 6'(i), 6'd20, 6'd3)) begin n_fail++; $display("FAIL indep_issue_inst[%0d]: got %h expected %h", i, iss_inst[i], mk(T_MULI, 6'(i), 6'd20, 6'd3)); end
    end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL indep_stall: got %0d expected 0", stall_cnt); end
    n_checks++; if (wb_cyc.size() != 4) begin n_fail++; $display("FAIL indep_wb_count: got %0d expected 4", wb_cyc.size()); end
    for (int i = 0; i < 4 && i < wb_cyc.size(); i++) begin
      n_checks++; if (wb_cyc[i] !== base + 4 + i) begin n_fail++; $display("FAIL indep_wb_cyc[%0d]: got %0d expected %0d", i, wb_cyc[i] - base, 4 + i); end
      n_checks++; if (wb_adr[i] !== 6'(i)) begin n_fail++; $display("FAIL indep_wb_addr[%0d]: got %0d expected %0d", i, wb_adr[i], i); end
    end
    n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL indep_done_count: got %0d expected 1", done_cyc.size()); end
    else begin
      n_checks++; if (done_cyc[0] !== base + 8) begin n_fail++; $display("FAIL indep_done_cyc: got %0d expected 8", done_cyc[0] - base); end
      n_checks++; if (done_busy[0] !== 1'b0) begin n_fail++; $display("FAIL indep_busy_at_done: got %0b expected 0", done_busy[0]); end
    end
  endtask

  task automatic test_raw;
    int ei[2];
    ei = '{0, 5};
    load_inst(6'd0, mk(T_MULI, 6'd8, 6'd4, 6'd3));
    load_inst(6'd1, mk(T_ADD, 6'd9, 6'd8, 6'd1));
    kick(7'd2);
    wait_done(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL raw_timeout: done not seen within 100 cycles"); end
    n_checks++; if (iss_cyc.size() != 2) begin n_fail++; $display("FAIL raw_issue_count: got %0d expected 2", iss_cyc.size()); end
    for (int i = 0; i < 2 && i < iss_cyc.size(); i++) begin
      n_checks++; if (iss_cyc[i] !== base + ei[i]) begin n_fail++; $display("FAIL raw_issue_cyc[%0d]: got %0d expected %0d", i, iss_cyc[i] - base, ei[i]); end
    end
    n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL raw_stall: got %0d expected 4", stall_cnt); end
    n_checks++; if (wb_cyc.size() != 2) begin n_fail++; $display("FAIL raw_wb_count: got %0d expected 2", wb_cyc.size()); end
    else begin
      n_checks++; if (wb_cyc[1] !== base + 9 || wb_adr[1] !== 6'd9) begin n_fail++; $display("FAIL raw_wb_r9: got cycle %0d reg %0d expected cycle 9 reg 9", wb_cyc[1] - base, wb_adr[1]); end
    end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] !== base + 10) begin n_fail++; $display("FAIL raw_done: got %0d pulses, first at %0d expected 1 at 10", done_cyc.size(), done_cyc.size() ? done_cyc[0] - base : -1); end
  endtask

  task automatic test_imm;
    load_inst(6'd0, mk(T_MULI, 6'd8, 6'd4, 6'd3));
    load_inst(6'd1, mk(T_MULI, 6'd9, 6'd6, 6'd8));
    kick(7'd2);
    wait_done(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL imm_timeout: done not seen within 100 cycles"); end
    n_checks++; if (iss_cyc.size() != 2 || iss_cyc[1] !== base + 1) begin n_fail++; $display("FAIL imm_second_issue: got %0d issues, second at %0d expected 2, at 1", iss_cyc.size(), iss_cyc.size() > 1 ? iss_cyc[1] - base : -1); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL imm_stall: got %0d expected 0", stall_cnt); end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] !== base + 6) begin n_fail++; $display("FAIL imm_done: got %0d pulses, first at %0d expected 1 at 6", done_cyc.size(), done_cyc.size() ? done_cyc[0] - base : -1); end
  endtask

  task automatic test_waw_nop;
    int ei[2];
    ei = '{0, 5};
    load_inst(6'd0, mk(T_MUL, 6'd5, 6'd1, 6'd2));
    load_inst(6'd1, mk(T_NOP, 6'd0, 6'd0, 6'd0));
    load_inst(6'd2, mk(T_MUL, 6'd5, 6'd3, 6'd4));
    kick(7'd3);
    wait_done(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL waw_timeout: done not seen within 100 cycles"); end
    n_checks++; if (iss_cyc.size() != 2) begin n_fail++; $display("FAIL waw_issue_count: got %0d expected 2", iss_cyc.size()); end
    for (int i = 0; i < 2 && i < iss_cyc.size(); i++) begin
      n_checks++; if (iss_cyc[i] !== base + ei[i]) begin n_fail++; $display("FAIL waw_issue_cyc[%0d]: got %0d expected %0d", i, iss_cyc[i] - base, ei[i]); end
    end
    n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL waw_stall: got %0d expected 3", stall_cnt); end
    n_checks++; if (wb_cyc.size() != 2 || wb_cyc[0] !== base + 4 || wb_cyc[1] !== base + 9) begin n_fail++; $display("FAIL waw_wb: got %0d writebacks expected 2 at 4 and 9", wb_cyc.size()); end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] !== base + 10) begin n_fail++; $display("FAIL waw_done: got %0d pulses, first at %0d expected 1 at 10", done_cyc.size(), done_cyc.size() ? done_cyc[0] - base : -1); end
  endtask

  task automatic test_zero_len;
    kick(7'd0);
    wait_done(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL zero_timeout: done not seen within 100 cycles"); end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] !== s_cyc + 1) begin n_fail++; $display("FAIL zero_done: got %0d pulses expected 1 one cycle after start", done_cyc.size()); end
    n_checks++; if (done_busy.size() != 0 && done_busy[0] !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %0b expected 0", done_busy[0]); end
    n_checks++; if (iss_cyc.size() != 0) begin n_fail++; $display("FAIL zero_issue: got %0d issues expected 0", iss_cyc.size()); end
    n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL zero_stall_hold: got %0d expected 3", stall_cnt); end
  endtask

  task automatic test_ignore_in_run;
    for (int k = 0; k < 4; k++) load_inst(6'(k), mk(T_MULI, 6'(k), 6'd20, 6'd3));
    kick(7'd4);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %0b expected 1", busy); end
    ld_wren = 1'b1; ld_addr = 6'd3; ld_data = mk(T_ADD, 6'd30, 6'd31, 6'd29);
    start = 1'b1; prog_len = 7'd1;
    @(posedge bus_clk); #1;
    ld_wren = 1'b0; start = 1'b0;
    wait_done(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL ign_timeout: done not seen within 100 cycles"); end
    n_checks++; if (iss_cyc.size() != 4) begin n_fail++; $display("FAIL ign_issue_count: got %0d expected 4", iss_cyc.size()); end
    else begin
      n_checks++; if (iss_inst[3] !== mk(T_MULI, 6'd3, 6'd20, 6'd3)) begin n_fail++; $display("FAIL ign_inst3: got %h expected %h", iss_inst[3], mk(T_MULI, 6'd3, 6'd20, 6'd3)); end
    end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] !== base + 8) begin n_fail++; $display("FAIL ign_done: got %0d pulses expected 1 at 8", done_cyc.size()); end
    kick(7'd4);
    wait_done(to);
    n_checks++; if (iss_cyc.size() != 4 || iss_inst[3] !== mk(T_MULI, 6'd3, 6'd20, 6'd3)) begin n_fail++; $display("FAIL ign_rerun_inst3: got %0d issues, last %h expected 4, %h", iss_cyc.size(), iss_inst.size() ? iss_inst[iss_inst.size()-1] : 24'h0, mk(T_MULI, 6'd3, 6'd20, 6'd3)); end
  endtask

  task automatic test_reset_mid_run;
    kick(7'd4);
    for (int k = 0; k < 20; k++) begin
      @(negedge bus_clk); #1;
      if (iss_cyc.size() >= 2) break;
    end
    n_checks++; if (iss_cyc.size() != 2) begin n_fail++; $display("FAIL rst_pre_issues: got %0d expected 2", iss_cyc.size()); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async: got busy %0b issue_valid %0b expected 0 0", busy, issue_valid); end
    @(posedge bus_clk); #1; clr_req = 1'b1;
    @(posedge bus_clk); #1; clr_req = 1'b0; rst_n = 1'b1;
    repeat (12) begin @(posedge bus_clk); #1; end
    n_checks++; if (wb_cyc.size() != 0) begin n_fail++; $display("FAIL rst_wb: got %0d writebacks expected 0", wb_cyc.size()); end
    n_checks++; if (done_cyc.size() != 0) begin n_fail++; $display("FAIL rst_done: got %0d pulses expected 0", done_cyc.size()); end
    n_checks++; if (busy !== 1'b0 || iss_cyc.size() != 0) begin n_fail++; $display("FAIL rst_idle: got busy %0b issues %0d expected 0 0", busy, iss_cyc.size()); end
    kick(7'd4);
    wait_done(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rerun_timeout: done not seen within 100 cycles"); end
    n_checks++; if (wb_cyc.size() != 4 || wb_adr[3] !== 6'd3 || wb_cyc[3] !== base + 7) begin n_fail++; $display("FAIL rerun_wb: got %0d writebacks expected 4, last R3 at 7", wb_cyc.size()); end
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] !== base + 8) begin n_fail++; $display("FAIL rerun_done: got %0d pulses expected 1 at 8", done_cyc.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; ld_wren = 1'b0; ld_addr = '0; ld_data = '0; prog_len = '0; start = 1'b0;
    test_reset();
    test_independent();
    test_raw();
    test_imm();
    test_waw_nop();
    test_zero_len();
    test_ignore_in_run();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
